// File: rtl/requant_pkg.sv
// requant_pkg: shared types and constants for the requantisation parameter store.
//   - load FSM state enum
//   - default parameter widths/sizes
//   - packed entry layout {shift, mult} at default widths
//   - clog2_min1(): index width helper that never returns 0
package requant_pkg;

    localparam int unsigned DefNumLayers   = 6;
    localparam int unsigned DefMaxChannels = 64;
    localparam int unsigned DefMultWidth   = 32;
    localparam int unsigned DefShiftWidth  = 6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } load_state_e;

    // Entry layout as carried on load_data and stored in the RAM.
    typedef struct packed {
        logic signed [DefShiftWidth-1:0] shift;
        logic signed [DefMultWidth-1:0]  mult;
    } requant_entry_t;

    // Index width for n items; a single item still needs a 1-bit index.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/requant_param_ram.sv
// requant_param_ram: simple dual-port synchronous RAM (one write port, one read port).
// Read data is registered: a read enabled at cycle N appears on rdata_o at cycle N+1.
// Contents are not reset.
// Ports:
//   clk_i            clock
//   we_i/waddr_i/wdata_i   write port
//   re_i/raddr_i           read port (read register holds when re_i is low)
//   rdata_o          registered read data
module requant_param_ram
    import requant_pkg::*;
#(
    parameter int unsigned Depth = DefNumLayers * DefMaxChannels,
    parameter int unsigned Width = DefMultWidth + DefShiftWidth,
    localparam int unsigned AddrW = clog2_min1(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/requant_param_store.sv
// requant_param_store: per-layer store of requantisation {shift, mult} parameters.
// A layer is loaded as a burst of load_num_ch beats (1 = per-tensor); reads return the
// entry for (rd_layer, rd_ch) one cycle after acceptance, or zeros with out_err set when
// the layer is unloaded/out of range or the channel is beyond the stored count.
// Optional feature: define REQUANT_STORE_PARITY_EN to store an even-parity bit per entry;
// a parity mismatch on read zeroes the data and raises out_err.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   load_start/load_layer/load_num_ch  start a layer load (accepted only when idle)
//   load_valid/load_data/load_ready    beat handshake, load_data = {shift, mult}
//   load_done                        one-cycle pulse after the final beat
//   rd_valid/rd_ready/rd_layer/rd_ch   read request handshake (not ready while loading)
//   out_valid/out_mult/out_shift/out_err  read result, all zero when out_valid is low
module requant_param_store
    import requant_pkg::*;
#(
    parameter int unsigned NUM_LAYERS   = DefNumLayers,
    parameter int unsigned MAX_CHANNELS = DefMaxChannels,
    parameter int unsigned MULT_WIDTH   = DefMultWidth,
    parameter int unsigned SHIFT_WIDTH  = DefShiftWidth,
    localparam int unsigned LW = clog2_min1(NUM_LAYERS),
    localparam int unsigned CW = clog2_min1(MAX_CHANNELS),
    localparam int unsigned NW = CW + 1,
    localparam int unsigned DW = MULT_WIDTH + SHIFT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_start,
    input  logic [LW-1:0]                 load_layer,
    input  logic [NW-1:0]                 load_num_ch,
    input  logic                          load_valid,
    input  logic [DW-1:0]                 load_data,
    output logic                          load_ready,
    output logic                          load_done,
    input  logic                          rd_valid,
    output logic                          rd_ready,
    input  logic [LW-1:0]                 rd_layer,
    input  logic [CW-1:0]                 rd_ch,
    output logic                          out_valid,
    output logic signed [MULT_WIDTH-1:0]  out_mult,
    output logic signed [SHIFT_WIDTH-1:0] out_shift,
    output logic                          out_err
);

    localparam int unsigned Depth = NUM_LAYERS * MAX_CHANNELS;
    localparam int unsigned AW    = clog2_min1(Depth);
`ifdef REQUANT_STORE_PARITY_EN
    localparam int unsigned RW    = DW + 1;
`else
    localparam int unsigned RW    = DW;
`endif

    localparam logic [LW:0]   NumLayersW = (LW + 1)'(NUM_LAYERS);
    localparam logic [NW-1:0] MaxChW     = NW'(MAX_CHANNELS);
    localparam logic [AW-1:0] RowStride  = AW'(MAX_CHANNELS);

    // ------------------------------------------------------------------
    // Load FSM
    // ------------------------------------------------------------------
    load_state_e           state_q, state_d;
    logic [LW-1:0]         layer_q, layer_d;
    logic [NW-1:0]         num_q, num_d;
    logic [NW-1:0]         cnt_q, cnt_d;
    logic [NUM_LAYERS-1:0] loaded_q, loaded_d;
    logic [NW-1:0]         count_q [NUM_LAYERS];

    logic [NW-1:0] num_clamped;
    logic          start_layer_ok;
    logic          cur_layer_ok;
    logic          beat_acc;
    logic          store_cnt;

    always_comb begin
        num_clamped = load_num_ch;
        if (load_num_ch == '0) begin
            num_clamped = NW'(1);
        end else if (load_num_ch > MaxChW) begin
            num_clamped = MaxChW;
        end
    end

    assign start_layer_ok = ({1'b0, load_layer} < NumLayersW);
    assign cur_layer_ok   = ({1'b0, layer_q} < NumLayersW);

    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        num_d     = num_q;
        cnt_d     = cnt_q;
        loaded_d  = loaded_q;
        beat_acc  = 1'b0;
        store_cnt = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    state_d = StLoad;
                    layer_d = load_layer;
                    num_d   = num_clamped;
                    cnt_d   = '0;
                    if (start_layer_ok) begin
                        loaded_d[load_layer] = 1'b0;
                    end
                end
            end
            StLoad: begin
                if (load_valid) begin
                    beat_acc = 1'b1;
                    cnt_d    = cnt_q + NW'(1);
                    if (cnt_q == num_q - NW'(1)) begin
                        state_d = StDone;
                        // Flag and count become visible in the DONE cycle itself.
                        if (cur_layer_ok) begin
                            loaded_d[layer_q] = 1'b1;
                            store_cnt         = 1'b1;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            layer_q  <= '0;
            num_q    <= '0;
            cnt_q    <= '0;
            loaded_q <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            num_q    <= num_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
            if (store_cnt) begin
                count_q[layer_q] <= num_q;
            end
        end
    end

    assign load_ready = (state_q == StLoad);
    assign load_done  = (state_q == StDone);

    // ------------------------------------------------------------------
    // Read request decode
    // ------------------------------------------------------------------
    logic          rd_acc;
    logic          rd_layer_ok;
    logic [LW-1:0] rd_layer_idx;
    logic [NW-1:0] rd_cnt;
    logic          rd_per_tensor;
    logic          rd_err;
    logic [CW-1:0] rd_ch_eff;

    assign rd_ready      = (state_q != StLoad);
    assign rd_acc        = rd_valid && rd_ready;
    assign rd_layer_ok   = ({1'b0, rd_layer} < NumLayersW);
    assign rd_layer_idx  = rd_layer_ok ? rd_layer : '0;
    assign rd_cnt        = count_q[rd_layer_idx];
    assign rd_per_tensor = (rd_cnt == NW'(1));
    assign rd_err        = !rd_layer_ok || !loaded_q[rd_layer_idx] ||
                           (!rd_per_tensor && ({1'b0, rd_ch} >= rd_cnt));
    // Per-tensor layers always map to entry 0 of the layer.
    assign rd_ch_eff     = rd_per_tensor ? '0 : rd_ch;

    // ------------------------------------------------------------------
    // Parameter RAM
    // ------------------------------------------------------------------
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [RW-1:0] wdata;
    logic [RW-1:0] rdata;
    logic          ram_we;
    logic          ram_re;

    assign waddr  = AW'(layer_q) * RowStride + AW'(cnt_q);
    assign raddr  = AW'(rd_layer_idx) * RowStride + AW'(rd_ch_eff);
    assign ram_we = beat_acc && cur_layer_ok;
    // Erroring reads never touch the RAM; their data is zeroed anyway.
    assign ram_re = rd_acc && !rd_err;

`ifdef REQUANT_STORE_PARITY_EN
    assign wdata = {^load_data, load_data};
`else
    assign wdata = load_data;
`endif

    requant_param_ram #(
        .Depth (Depth),
        .Width (RW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .re_i    (ram_re),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    // ------------------------------------------------------------------
    // Result stage
    // ------------------------------------------------------------------
    logic out_valid_q;
    logic out_err_q;
    logic par_err;
    logic data_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            out_valid_q <= rd_acc;
            out_err_q   <= rd_acc && rd_err;
        end
    end

`ifdef REQUANT_STORE_PARITY_EN
    // Even parity: XOR over data plus stored parity bit is zero for a clean entry.
    assign par_err = out_valid_q && !out_err_q && (^rdata);
`else
    assign par_err = 1'b0;
`endif

    assign data_ok   = out_valid_q && !out_err_q && !par_err;
    assign out_valid = out_valid_q;
    assign out_err   = out_valid_q && (out_err_q || par_err);
    assign out_mult  = data_ok ? $signed(rdata[MULT_WIDTH-1:0]) : '0;
    assign out_shift = data_ok ? $signed(rdata[DW-1:MULT_WIDTH]) : '0;

endmodule

// File: tb/tb_requant_param_store.sv
module tb_requant_param_store;

    logic               clk;
    logic               rst_n;
    logic               load_start;
    logic [2:0]         load_layer;
    logic [6:0]         load_num_ch;
    logic               load_valid;
    logic [37:0]        load_data;
    logic               load_ready;
    logic               load_done;
    logic               rd_valid;
    logic               rd_ready;
    logic [2:0]         rd_layer;
    logic [5:0]         rd_ch;
    logic               out_valid;
    logic signed [31:0] out_mult;
    logic signed [5:0]  out_shift;
    logic               out_err;

    requant_param_store dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .load_layer  (load_layer),
        .load_num_ch (load_num_ch),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_layer    (rd_layer),
        .rd_ch       (rd_ch),
        .out_valid   (out_valid),
        .out_mult    (out_mult),
        .out_shift   (out_shift),
        .out_err     (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] mult;
        logic [5:0]  shift;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic [2:0]  layer;
        logic [5:0]  ch;
        logic [31:0] mult;
        logic [5:0]  shift;
        logic        err;
    } rd_vec_t;

    rd_vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one read request for one cycle; expected result goes to the scoreboard.
    task automatic do_read(input logic [2:0] layer, input logic [5:0] ch,
                           input logic [31:0] mult, input logic [5:0] shift, input logic err);
        exp_t e;
        rd_valid = 1'b1;
        rd_layer = layer;
        rd_ch    = ch;
        check("rd_ready_at_issue", rd_ready, 1'b1);
        if (rd_ready) begin
            e.mult  = mult;
            e.shift = shift;
            e.err   = err;
            sb_q.push_back(e);
        end
        step();
        rd_valid = 1'b0;
    endtask

    // Full layer load: beat i carries {sbase+i, mbase+i}; beats is the post-clamp count.
    task automatic do_load(input logic [2:0] layer, input logic [6:0] num, input int beats,
                           input logic [31:0] mbase, input logic [5:0] sbase, input bit gaps);
        load_layer  = layer;
        load_num_ch = num;
        load_start  = 1'b1;
        step();
        load_start = 1'b0;
        check("load_ready_in_load", load_ready, 1'b1);
        check("rd_ready_in_load", rd_ready, 1'b0);
        for (int i = 0; i < beats; i++) begin
            if (gaps && i == 1) begin
                load_valid = 1'b0;
                step();
            end
            load_valid = 1'b1;
            load_data  = {sbase + 6'(i), mbase + 32'(i)};
            step();
        end
        load_valid = 1'b0;
        check("load_done_pulse", load_done, 1'b1);
        check("load_ready_in_done", load_ready, 1'b0);
        check("rd_ready_in_done", rd_ready, 1'b1);
        step();
        check("load_done_clears", load_done, 1'b0);
    endtask

    // Output monitor: pops one expected result per valid output.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got 1, expected 0 at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("out_mult", 64'($unsigned(out_mult)), 64'(e.mult));
                    check("out_shift", 64'($unsigned(out_shift)), 64'(e.shift));
                    check("out_err", out_err, e.err);
                end
            end else begin
                check("idle_outputs_zero", {$unsigned(out_mult), $unsigned(out_shift), out_err},
                      '0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200us");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{3'd2, 6'd0,  32'h4000_0000, 6'd5,   1'b0};
        vecs[1]  = '{3'd2, 6'd3,  32'h4000_0003, 6'd8,   1'b0};
        vecs[2]  = '{3'd2, 6'd4,  32'h0,         6'd0,   1'b1};
        vecs[3]  = '{3'd0, 6'd17, 32'h7FFF_FFFF, 6'h3D,  1'b0};
        vecs[4]  = '{3'd0, 6'd0,  32'h7FFF_FFFF, 6'h3D,  1'b0};
        vecs[5]  = '{3'd5, 6'd0,  32'h0,         6'd0,   1'b1};
        vecs[6]  = '{3'd1, 6'd40, 32'h1234_5678, 6'h20,  1'b0};
        vecs[7]  = '{3'd3, 6'd63, 32'h0000_103F, 6'h3F,  1'b0};
        vecs[8]  = '{3'd3, 6'd0,  32'h0000_1000, 6'h00,  1'b0};
        vecs[9]  = '{3'd6, 6'd0,  32'h0,         6'd0,   1'b1};
        vecs[10] = '{3'd7, 6'd5,  32'h0,         6'd0,   1'b1};
        vecs[11] = '{3'd4, 6'd0,  32'h0,         6'd0,   1'b1};
        vecs[12] = '{3'd2, 6'd63, 32'h0,         6'd0,   1'b1};

        rst_n       = 1'b0;
        load_start  = 1'b0;
        load_layer  = '0;
        load_num_ch = '0;
        load_valid  = 1'b0;
        load_data   = '0;
        rd_valid    = 1'b0;
        rd_layer    = '0;
        rd_ch       = '0;

        #12;
        check("rst_load_ready", load_ready, 1'b0);
        check("rst_load_done", load_done, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_err", out_err, 1'b0);
        check("rst_out_data", {$unsigned(out_mult), $unsigned(out_shift)}, '0);
        step();
        rst_n = 1'b1;
        step();
        check("rd_ready_after_reset", rd_ready, 1'b1);

        // Loads: layer 2 x4 (with a gap), per-tensor layer 0, count 0 -> 1, count 100 -> 64.
        do_load(3'd2, 7'd4,   4,  32'h4000_0000, 6'd5,  1'b1);
        do_load(3'd0, 7'd1,   1,  32'h7FFF_FFFF, 6'h3D, 1'b0);
        do_load(3'd1, 7'd0,   1,  32'h1234_5678, 6'h20, 1'b0);
        do_load(3'd3, 7'd100, 64, 32'h0000_1000, 6'h00, 1'b0);

        // Back-to-back table reads.
        for (int i = 0; i < 13; i++) begin
            do_read(vecs[i].layer, vecs[i].ch, vecs[i].mult, vecs[i].shift, vecs[i].err);
        end
        step();
        step();

`ifdef REQUANT_STORE_PARITY_EN
        dut.u_ram.mem_q[2*64+1] = dut.u_ram.mem_q[2*64+1] ^ 39'd8;
        do_read(3'd2, 6'd1, 32'h0, 6'd0, 1'b1);
        do_read(3'd2, 6'd2, 32'h4000_0002, 6'd7, 1'b0);
        step();
        step();
`endif

        // Read attempt and second load_start while loading: both must be ignored.
        load_layer  = 3'd4;
        load_num_ch = 7'd4;
        load_start  = 1'b1;
        step();
        rd_valid    = 1'b1;
        rd_layer    = 3'd2;
        rd_ch       = 6'd0;
        check("rd_ready_low_in_load", rd_ready, 1'b0);
        load_layer  = 3'd5;
        load_num_ch = 7'd1;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = {6'd1 + 6'(i), 32'h0BAD_0000 + 32'(i)};
            step();
            load_start = 1'b0;
            if (i < 3) begin
                check("still_loading", load_ready, 1'b1);
                check("no_early_done", load_done, 1'b0);
            end
        end
        rd_valid   = 1'b0;
        load_valid = 1'b0;
        check("load_done_after_4th", load_done, 1'b1);
        step();
        do_read(3'd4, 6'd3, 32'h0BAD_0003, 6'd4, 1'b0);
        do_read(3'd5, 6'd0, 32'h0,         6'd0, 1'b1);
        step();
        step();

        // Reset in the middle of a load.
        load_layer  = 3'd5;
        load_num_ch = 7'd4;
        load_start  = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_data  = {6'd9, 32'h5555_0000 + 32'(i)};
            step();
        end
        rst_n = 1'b0;
        #1;
        check("abort_load_ready", load_ready, 1'b0);
        check("abort_load_done", load_done, 1'b0);
        check("abort_rd_ready_idle", rd_ready, 1'b1);
        check("abort_outputs", {out_valid, out_err, $unsigned(out_mult), $unsigned(out_shift)},
              '0);
        load_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("abort_rd_ready", rd_ready, 1'b1);
        do_read(3'd5, 6'd0, 32'h0, 6'd0, 1'b1);
        do_read(3'd2, 6'd3, 32'h0, 6'd0, 1'b1);
        do_read(3'd0, 6'd0, 32'h0, 6'd0, 1'b1);
        step();
        step();
        step();
        check("scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/requant_param_store.md
REQUANT_PARAM_STORE -- requirements
Module: requant_param_store

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 6, number of layers held.
REQ-002 SHALL have parameter MAX_CHANNELS, default 64, per-layer channel capacity.
REQ-003 SHALL have parameter MULT_WIDTH, default 32, signed multiplier width.
REQ-004 SHALL have parameter SHIFT_WIDTH, default 6, signed shift width.
REQ-005 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1; reset is asynchronous, active-low.
REQ-007 SHALL have port load_start, input, 1, begin loading one layer.
REQ-008 SHALL have port load_layer, input, clog2(NUM_LAYERS), layer being loaded.
REQ-009 SHALL have port load_num_ch, input, clog2(MAX_CHANNELS)+1, entries to load (1 = per-tensor).
REQ-010 SHALL have port load_valid, input, 1, load_data beat valid.
REQ-011 SHALL have port load_data, input, MULT_WIDTH+SHIFT_WIDTH, {shift, mult}.
REQ-012 SHALL have port load_ready, output, 1, beat accepted when load_valid and load_ready.
REQ-013 SHALL have port load_done, output, 1, one-cycle pulse after last beat.
REQ-014 SHALL have ports rd_valid (input, 1), rd_ready (output, 1), rd_layer (input, clog2(NUM_LAYERS)), rd_ch (input, clog2(MAX_CHANNELS)).
REQ-015 SHALL have ports out_valid (output, 1), out_mult (output, signed MULT_WIDTH), out_shift (output, signed SHIFT_WIDTH), out_err (output, 1).

Function
REQ-016 SHALL implement FSM IDLE -> LOAD -> DONE -> IDLE; IDLE->LOAD on load_start; LOAD->DONE on final accepted beat; DONE lasts one cycle, asserts load_done.
REQ-017 SHALL, on load_start, latch load_layer and load_num_ch, clear that layer's loaded flag, reset beat counter to 0.
REQ-018 SHALL assert load_ready only in LOAD; each accepted beat writes entry layer*MAX_CHANNELS+counter, counter increments.
REQ-019 SHALL, on entering DONE, set the layer's loaded flag and store its channel count.
REQ-020 SHALL ignore load_start outside IDLE; load_num_ch of 0 or above MAX_CHANNELS SHALL be clamped to 1 and MAX_CHANNELS respectively.
REQ-021 SHALL assert rd_ready in IDLE and DONE only; deassert in LOAD.
REQ-022 SHALL, for a request accepted at cycle N, present out_valid=1 with data at cycle N+1 (latency 1, synchronous RAM), one result per accepted request, no output backpressure.
REQ-023 SHALL, for per-tensor layers (count 1), ignore rd_ch and return entry 0.
REQ-024 SHALL, for unloaded layer, rd_layer >= NUM_LAYERS, or rd_ch >= stored count (count>1), return out_mult=0, out_shift=0, out_err=1.
REQ-025 SHALL drive out_mult, out_shift, out_err to 0 whenever out_valid=0.
REQ-026 SHALL allow back-to-back reads, one per cycle.

Reset
REQ-027 SHALL, on rst_n low, force FSM to IDLE, clear all loaded flags, counters, counts, and outputs (load_ready, load_done, out_valid, out_err, out_mult, out_shift = 0); rd_ready=1 after release.
REQ-028 SHALL not reset parameter RAM contents; a load aborted by reset leaves that layer unloaded.

Configuration
REQ-029 SHALL support macro REQUANT_STORE_PARITY_EN: when defined, store one even-parity bit per entry, check on read, assert out_err on mismatch with data zeroed; when undefined, no parity storage or check.

Structure
REQ-030 SHALL place FSM state enum, entry typedef {shift, mult} and default width constants in shared package requant_pkg.
REQ-031 SHALL instantiate sub-module requant_param_ram (single-port-write, single-port-read synchronous RAM, depth NUM_LAYERS*MAX_CHANNELS).

Verification
REQ-032 Load layer 2, count 4, entries mult 0x40000000..0x40000003, shift 5..8 -> load_done one cycle after 4th beat; read (2,3) -> next cycle mult 0x40000003, shift 8, out_err 0.
REQ-033 Load layer 0 count 1 (mult 0x7FFFFFFF, shift -3); read (0,17) -> mult 0x7FFFFFFF, shift -3, out_err 0.
REQ-034 Read unloaded layer 5 or (2,4) after REQ-032 load -> mult 0, shift 0, out_err 1.
REQ-035 Assert rst_n low after 2 of 4 beats -> outputs 0, FSM IDLE; read of that layer -> out_err 1.
REQ-036 rd_valid during LOAD -> rd_ready 0, no out_valid; load_start during LOAD -> ignored, original load completes.
REQ-037 With REQUANT_STORE_PARITY_EN, force flipped bit in entry (2,1) -> read returns zeros, out_err 1.
